// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared processor constants for the instruction-fetch slice: the machine word
// width and the default fetch-stage parameters (instruction-memory address
// width, reset PC and the bubble instruction). Also provides the word
// increment helper used for PC+1 arithmetic (wraps mod 2^32).
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int                WORD_W       = 32;
    localparam int                DEF_ADDR_W   = 12;
    localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEF_NOP      = 32'h0000_0000;

    typedef logic [WORD_W-1:0] word_t;

    // PC+1; the carry out of the top bit is dropped so 32'hFFFFFFFF wraps to 0.
    function automatic word_t inc_word(input word_t w);
        return w + word_t'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's bus signals: the synchronous instruction-memory
// port and the F/D pipeline-register write port.
//   imem_addr   : word address to instruction memory (ADDR_W bits)
//   imem_q      : instruction word for the address presented on the previous edge
//   out_IR      : instruction word to the F/D register (NOP for bubbles)
//   out_PC_next : PC+1 of out_IR
//   fd_wren     : write enable for the F/D register
// Modports: master = fetch stage, slave = memory / F/D register side.
// -----------------------------------------------------------------------------
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0] imem_addr;
    word_t             imem_q;
    word_t             out_IR;
    word_t             out_PC_next;
    logic              fd_wren;

    modport master (
        output imem_addr,
        output out_IR,
        output out_PC_next,
        output fd_wren,
        input  imem_q
    );

    modport slave (
        input  imem_addr,
        input  out_IR,
        input  out_PC_next,
        input  fd_wren,
        output imem_q
    );

endinterface

// File: rtl/fetch_stage_pc_next.sv
// -----------------------------------------------------------------------------
// pc_next_logic
// Next-PC priority mux for the fetch stage: redirect > stall > increment.
// Purely combinational; the pc register itself lives in fetch_stage.
// Ports:
//   pc              : current pc
//   stall           : hold request from decode
//   redirect_valid  : taken branch/jump resolved downstream
//   redirect_target : word address to fetch next on redirect
//   pc_next         : value to load into pc on the next rising edge
// -----------------------------------------------------------------------------
module pc_next_logic
    import fetch_stage_pkg::*;
(
    input  word_t pc,
    input  logic  stall,
    input  logic  redirect_valid,
    input  word_t redirect_target,
    output word_t pc_next
);

    always_comb begin
        pc_next = inc_word(pc);
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (stall) begin
            pc_next = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage in front of a 1-cycle-latency synchronous
// instruction memory. pc addresses the memory; pc_issued tags the word that
// returns on imem_q one edge later, and data_valid says whether that word is
// a real instruction or a bubble (after reset or redirect).
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   stall                 : hazard stall from decode, freezes the stage
//   redirect_valid/target : taken branch/jump, overrides stall
//   fetch_count           : number of valid instructions delivered to F/D
//   bus (master)          : imem_addr/imem_q, out_IR/out_PC_next/fd_wren
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int    ADDR_W   = DEF_ADDR_W,
    parameter word_t RESET_PC = DEF_RESET_PC,
    parameter word_t NOP      = DEF_NOP
)(
    input  logic  clock,
    input  logic  reset,
    input  logic  stall,
    input  logic  redirect_valid,
    input  word_t redirect_target,
    output word_t fetch_count,
    fetch_stage_if.master bus
);

    word_t pc;
    word_t pc_next;
    word_t pc_issued;
    logic  data_valid;
    logic  from_mem;
    word_t count;

    pc_next_logic u_pc_next (
        .pc              (pc),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_next         (pc_next)
    );

    // A redirect squashes the word currently on imem_q: it was fetched down
    // the wrong path.
    assign from_mem = data_valid & ~redirect_valid;

    assign bus.imem_addr   = pc[ADDR_W-1:0];
    // Redirect forces a write so the wrong-path slot in F/D becomes a NOP.
    assign bus.fd_wren     = ~stall | redirect_valid;
    assign bus.out_IR      = from_mem ? bus.imem_q : NOP;
    assign bus.out_PC_next = inc_word(pc_issued);
    assign fetch_count     = count;

    // pc_issued advances under the same condition as the memory read it
    // tags, so the tag and imem_q always refer to the same address.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            pc_issued  <= RESET_PC;
            data_valid <= 1'b0;
            count      <= '0;
        end else begin
            pc <= pc_next;
            if (bus.fd_wren) begin
                pc_issued <= pc;
            end
            if (redirect_valid) begin
                data_valid <= 1'b0;
            end else if (!stall) begin
                data_valid <= 1'b1;
            end
            if (bus.fd_wren && from_mem) begin
                count <= inc_word(count);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The instruction memory model returns
// 0xA000_0000 + address, registered on the rising edge, and only reads when
// the F/D register is written (a stalled memory holds its output word).
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int ADDR_W = 12;

    logic  clock;
    logic  reset;
    logic  stall;
    logic  redirect_valid;
    word_t redirect_target;
    word_t fetch_count;

    int vectors;
    int miscompares;

    fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_count     (fetch_count),
        .bus             (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.fd_wren) begin
            bus.imem_q <= 32'hA000_0000 + 32'(bus.imem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the full visible state of one cycle.
    task automatic chk_cycle(input string tag, input logic [31:0] ir, input logic [31:0] pcn,
                             input logic [31:0] cnt);
        chk({tag, ".out_IR"}, bus.out_IR, ir);
        chk({tag, ".out_PC_next"}, bus.out_PC_next, pcn);
        chk({tag, ".fetch_count"}, fetch_count, cnt);
    endtask

    // Advance one rising edge; inputs may be changed afterwards, then settle.
    task automatic edge_step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;

        // Reset then free-run
        edge_step();
        edge_step();
        reset = 1'b0;
        #1;
        chk_cycle("rst", 32'h0, 32'd1, 32'd0);
        chk("rst.imem_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst.fd_wren", 32'(bus.fd_wren), 32'd1);

        edge_step();
        chk_cycle("run0", 32'hA000_0000, 32'd1, 32'd0);
        chk("run0.imem_addr", 32'(bus.imem_addr), 32'h1);
        edge_step();
        chk_cycle("run1", 32'hA000_0001, 32'd2, 32'd1);
        edge_step();
        chk_cycle("run2", 32'hA000_0002, 32'd3, 32'd2);
        for (int k = 3; k <= 5; k++) begin
            edge_step();
            chk_cycle("runk", 32'hA000_0000 + 32'(k), 32'(k + 1), 32'(k));
        end

        // Stall for three cycles while out_IR = A0000005
        stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) edge_step();
            chk_cycle("stall", 32'hA000_0005, 32'd6, 32'd5);
            chk("stall.imem_addr", 32'(bus.imem_addr), 32'h6);
            chk("stall.fd_wren", 32'(bus.fd_wren), 32'd0);
        end
        edge_step();
        stall = 1'b0;
        #1;
        chk_cycle("release", 32'hA000_0005, 32'd6, 32'd5);
        chk("release.fd_wren", 32'(bus.fd_wren), 32'd1);
        for (int k = 6; k <= 16; k++) begin
            edge_step();
            chk_cycle("after_stall", 32'hA000_0000 + 32'(k), 32'(k + 1), 32'(k));
        end

        // Redirect to 0x40 while out_IR = A0000010
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        #1;
        chk_cycle("redir0", 32'h0, 32'h11, 32'd16);
        chk("redir0.fd_wren", 32'(bus.fd_wren), 32'd1);
        edge_step();
        redirect_valid = 1'b0;
        #1;
        chk_cycle("redir1", 32'h0, 32'h12, 32'd16);
        chk("redir1.imem_addr", 32'(bus.imem_addr), 32'h40);
        edge_step();
        chk_cycle("redir2", 32'hA000_0040, 32'h41, 32'd16);
        edge_step();
        chk_cycle("redir3", 32'hA000_0041, 32'h42, 32'd17);

        // Stall and redirect together, target 0x80
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        #1;
        chk_cycle("both0", 32'h0, 32'h42, 32'd17);
        chk("both0.fd_wren", 32'(bus.fd_wren), 32'd1);
        edge_step();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk_cycle("both1", 32'h0, 32'h43, 32'd17);
        chk("both1.imem_addr", 32'(bus.imem_addr), 32'h80);
        edge_step();
        chk_cycle("both2", 32'hA000_0080, 32'h81, 32'd17);
        edge_step();
        chk_cycle("both3", 32'hA000_0081, 32'h82, 32'd18);

        // Redirect to the top of the address space; pc wraps
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        #1;
        edge_step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap0.imem_addr", 32'(bus.imem_addr), 32'hFFF);
        chk_cycle("wrap0", 32'h0, 32'h83, 32'd18);
        edge_step();
        chk("wrap1.imem_addr", 32'(bus.imem_addr), 32'h000);
        chk_cycle("wrap1", 32'hA000_0FFF, 32'h0000_0000, 32'd18);
        edge_step();
        chk("wrap2.imem_addr", 32'(bus.imem_addr), 32'h001);
        chk_cycle("wrap2", 32'hA000_0000, 32'h0000_0001, 32'd19);

        // Redirect, then stall, with reset pulsed in the middle
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        edge_step();
        redirect_valid = 1'b0;
        stall          = 1'b1;
        #1;
        chk("mid0.fd_wren", 32'(bus.fd_wren), 32'd0);
        chk("mid0.out_IR", bus.out_IR, 32'h0);
        edge_step();
        reset = 1'b1;
        #1;
        edge_step();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk("rst2.imem_addr", 32'(bus.imem_addr), 32'h0);
        chk_cycle("rst2", 32'h0, 32'd1, 32'd0);
        edge_step();
        chk_cycle("rst2.run0", 32'hA000_0000, 32'd1, 32'd0);
        edge_step();
        chk_cycle("rst2.run1", 32'hA000_0001, 32'd2, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
